// File: rtl/float_rounder_if.sv
// Handshake and data bundle between an upstream arithmetic stage, the rounder
// and the downstream consumer of packed IEEE-754 single-precision results.
interface float_rounder_if;
    logic        valid_in;
    logic        ready_out;
    logic        valid_out;
    logic        ready_in;
    logic [23:0] man_in;
    logic [9:0]  exp_in;
    logic        sgn_in;
    logic        round_in;
    logic        sticky_in;
    logic        IV_in;
    logic [2:0]  rm;
    logic        skip_round;
    logic [31:0] float_out;
    logic        NV;
    logic        OF;
    logic        UF;
    logic        NX;

    modport master (
        output valid_in, ready_in, man_in, exp_in, sgn_in, round_in, sticky_in,
               IV_in, rm, skip_round,
        input  ready_out, valid_out, float_out, NV, OF, UF, NX
    );

    modport slave (
        input  valid_in, ready_in, man_in, exp_in, sgn_in, round_in, sticky_in,
               IV_in, rm, skip_round,
        output ready_out, valid_out, float_out, NV, OF, UF, NX
    );
endinterface

// File: rtl/float_rounder.sv
// Rounds an unrounded mantissa/exponent pair into an IEEE-754 single, with an
// optional one-cycle denormalisation step and overflow saturation by mode.
module float_rounder (
    input  logic           clk,
    input  logic           reset,
    float_rounder_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DENORM = 2'd1;
    localparam logic [1:0] S_ROUND  = 2'd2;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic [1:0]  r_state;
    logic [23:0] r_man;
    logic [9:0]  r_exp;
    logic        r_sgn;
    logic        r_round;
    logic        r_sticky;
    logic        r_iv;
    logic [2:0]  r_rm;
    logic        r_tiny;
    logic        r_zero;
    logic        r_valid;
    logic [31:0] r_float;
    logic        r_nv;
    logic        r_of;
    logic        r_uf;
    logic        r_nx;

    logic               w_accept;
    logic               w_handshake;
    logic               w_goDenorm;
    logic signed [10:0] w_expBase;
    logic signed [10:0] w_shiftRaw;
    logic [10:0]        w_shiftSat;
    logic [49:0]        w_ext;
    logic               w_inc;
    logic [24:0]        w_sum;
    logic [22:0]        w_manFinal;
    logic signed [10:0] w_expFinal;
    logic               w_overflow;
    logic               w_maxFinite;
    logic               w_inexact;

    assign bus.ready_out = (r_state == S_IDLE) && (!r_valid || bus.ready_in);
    assign bus.valid_out = r_valid;
    assign bus.float_out = r_float;
    assign bus.NV        = r_nv;
    assign bus.OF        = r_of;
    assign bus.UF        = r_uf;
    assign bus.NX        = r_nx;

    assign w_accept    = bus.valid_in && bus.ready_out;
    assign w_handshake = r_valid && bus.ready_in;
    assign w_goDenorm  = ($signed(bus.exp_in) < 10'sd1) && (bus.man_in != 24'd0);

    // Denormalisation: a 26-bit guard field below the mantissa captures the
    // last shifted-out bit (round) and everything beneath it (sticky).
    assign w_expBase  = $signed({r_exp[9], r_exp});
    assign w_shiftRaw = 11'sd1 - w_expBase;
    assign w_shiftSat = (w_shiftRaw > 11'sd26) ? 11'd26 : w_shiftRaw;
    assign w_ext      = {r_man, 26'd0} >> w_shiftSat;

    always_comb begin
        w_inc = 1'b0;
        case (r_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r_sgn && (r_round || r_sticky);
            RM_RUP:  w_inc = !r_sgn && (r_round || r_sticky);
            RM_RMM:  w_inc = r_round;
            default: w_inc = r_round && (r_sticky || r_man[0]);
        endcase
    end

    assign w_sum = {1'b0, r_man} + {24'd0, w_inc};

    // A carry renormalises; a denormal that rounds up into the hidden bit
    // becomes the smallest normal exponent.
    always_comb begin
        w_manFinal = w_sum[22:0];
        w_expFinal = w_expBase;
        if (w_sum[24]) begin
            w_manFinal = w_sum[23:1];
            w_expFinal = w_expBase + 11'sd1;
        end else if ((w_expBase == 11'sd0) && w_sum[23]) begin
            w_expFinal = 11'sd1;
        end
    end

    assign w_overflow  = (w_expFinal >= 11'sd255);
    assign w_maxFinite = (r_rm == RM_RTZ) || ((r_rm == RM_RDN) && !r_sgn) ||
                         ((r_rm == RM_RUP) && r_sgn);
    assign w_inexact   = r_round || r_sticky;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_man    <= 24'd0;
            r_exp    <= 10'd0;
            r_sgn    <= 1'b0;
            r_round  <= 1'b0;
            r_sticky <= 1'b0;
            r_iv     <= 1'b0;
            r_rm     <= RM_RNE;
            r_tiny   <= 1'b0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
            r_float  <= 32'd0;
            r_nv     <= 1'b0;
            r_of     <= 1'b0;
            r_uf     <= 1'b0;
            r_nx     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_man    <= bus.man_in;
                        r_exp    <= bus.exp_in;
                        r_sgn    <= bus.sgn_in;
                        r_round  <= bus.round_in;
                        r_sticky <= bus.sticky_in;
                        r_iv     <= bus.IV_in;
                        r_rm     <= (bus.rm > RM_RMM) ? RM_RNE : bus.rm;
                        r_tiny   <= 1'b0;
                        r_zero   <= (bus.man_in == 24'd0);
                        r_of     <= 1'b0;
                        r_uf     <= 1'b0;
                        r_nx     <= 1'b0;
                        // Pass-through results are packed on the accepting edge.
                        if (bus.skip_round) begin
                            r_valid <= 1'b1;
                            r_float <= {bus.sgn_in, bus.exp_in[7:0], bus.man_in[22:0]};
                            r_nv    <= bus.IV_in;
                            r_state <= S_IDLE;
                        end else begin
                            r_valid <= 1'b0;
                            r_float <= 32'd0;
                            r_nv    <= 1'b0;
                            r_state <= w_goDenorm ? S_DENORM : S_ROUND;
                        end
                    end else if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_float <= 32'd0;
                        r_nv    <= 1'b0;
                        r_of    <= 1'b0;
                        r_uf    <= 1'b0;
                        r_nx    <= 1'b0;
                    end
                end
                S_DENORM: begin
                    r_man    <= w_ext[49:26];
                    r_round  <= w_ext[25];
                    r_sticky <= (|w_ext[24:0]) || r_round || r_sticky;
                    r_exp    <= 10'd0;
                    r_tiny   <= 1'b1;
                    r_state  <= S_ROUND;
                end
                S_ROUND: begin
                    r_valid <= 1'b1;
                    r_nv    <= r_iv;
                    r_state <= S_IDLE;
                    if (r_zero) begin
                        r_float <= {r_sgn, 31'd0};
                        r_of    <= 1'b0;
                        r_uf    <= 1'b0;
                        r_nx    <= 1'b0;
                    end else if (w_overflow) begin
                        r_float <= w_maxFinite ? {r_sgn, 8'hFE, 23'h7FFFFF}
                                               : {r_sgn, 8'hFF, 23'd0};
                        r_of    <= 1'b1;
                        r_uf    <= r_tiny;
                        r_nx    <= 1'b1;
                    end else begin
                        r_float <= {r_sgn, w_expFinal[7:0], w_manFinal};
                        r_of    <= 1'b0;
                        r_uf    <= r_tiny && w_inexact;
                        r_nx    <= w_inexact;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_rounder.sv
// Directed-vector bench for float_rounder: each scenario task drives its own
// vectors and compares result, flags {NV,OF,UF,NX} and latency inline.
module tb_float_rounder;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    float_rounder_if bus ();

    float_rounder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [23:0] man;
        logic [9:0]  exp;
        logic        sgn;
        logic        rnd;
        logic        stk;
        logic        iv;
        logic [2:0]  rm;
        logic        skip;
        logic [31:0] f;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [23:0] man, input logic [9:0] exp,
                                input logic sgn, input logic rnd, input logic stk,
                                input logic iv, input logic [2:0] rm, input logic skip,
                                input logic [31:0] f, input logic [3:0] fl, input int lat);
        vec_t v;
        v.man = man; v.exp = exp; v.sgn = sgn; v.rnd = rnd; v.stk = stk;
        v.iv = iv; v.rm = rm; v.skip = skip; v.f = f; v.fl = fl; v.lat = lat;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.man_in     = v.man;
        bus.exp_in     = v.exp;
        bus.sgn_in     = v.sgn;
        bus.round_in   = v.rnd;
        bus.sticky_in  = v.stk;
        bus.IV_in      = v.iv;
        bus.rm         = v.rm;
        bus.skip_round = v.skip;
        bus.valid_in   = 1'b1;
    endtask

    // Present one vector, count edges from the accepting edge until valid_out.
    task automatic send(input vec_t v, output int lat);
        drive(v);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            bus.valid_in = 1'b0;
            lat++;
        end while (!bus.valid_out && lat < 10);
    endtask

    task automatic idle();
        bus.ready_in = 1'b1;
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (bus.ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b exp 1", bus.ready_out);
        end
        checks++;
        if ({bus.valid_out, bus.float_out, bus.NV, bus.OF, bus.UF, bus.NX} !== 37'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got v=%b f=%h fl=%b%b%b%b exp all zero",
                     bus.valid_out, bus.float_out, bus.NV, bus.OF, bus.UF, bus.NX);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_ready got %b exp 1", bus.ready_out);
        end
    endtask

    task automatic test_rounding();
        vec_t vs[7];
        int   lat;
        vs[0] = mk(24'hC00000, 10'd127, 0, 1, 0, 0, 3'b000, 0, 32'h3FC00000, 4'b0001, 2);
        vs[1] = mk(24'hFFFFFF, 10'd127, 0, 1, 1, 0, 3'b000, 0, 32'h40000000, 4'b0001, 2);
        vs[2] = mk(24'h800001, 10'd127, 0, 1, 0, 0, 3'b000, 0, 32'h3F800002, 4'b0001, 2);
        vs[3] = mk(24'h800000, 10'd127, 1, 0, 1, 0, 3'b010, 0, 32'hBF800001, 4'b0001, 2);
        vs[4] = mk(24'h800000, 10'd127, 1, 0, 1, 0, 3'b011, 0, 32'hBF800000, 4'b0001, 2);
        vs[5] = mk(24'h800000, 10'd127, 0, 1, 0, 1, 3'b100, 0, 32'h3F800001, 4'b1001, 2);
        vs[6] = mk(24'h800000, 10'd127, 0, 1, 0, 0, 3'b111, 0, 32'h3F800000, 4'b0001, 2);
        for (int i = 0; i < 7; i++) begin
            idle();
            send(vs[i], lat);
            checks++;
            if ({bus.float_out, bus.NV, bus.OF, bus.UF, bus.NX} !== {vs[i].f, vs[i].fl}) begin
                errors++;
                $display("[TB] FAIL round_%0d got %h/%b%b%b%b exp %h/%b", i, bus.float_out,
                         bus.NV, bus.OF, bus.UF, bus.NX, vs[i].f, vs[i].fl);
            end
            checks++;
            if (lat !== vs[i].lat) begin
                errors++;
                $display("[TB] FAIL round_lat_%0d got %0d exp %0d", i, lat, vs[i].lat);
            end
        end
        // With ready_in high the result is consumed and outputs return to zero.
        @(posedge clk);
        #1;
        checks++;
        if ({bus.valid_out, bus.float_out, bus.NX} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL consume_clear got v=%b f=%h nx=%b exp 0", bus.valid_out,
                     bus.float_out, bus.NX);
        end
    endtask

    task automatic test_overflow_zero();
        vec_t vs[5];
        int   lat;
        vs[0] = mk(24'hFFFFFF, 10'd254, 0, 1, 0, 0, 3'b000, 0, 32'h7F800000, 4'b0101, 2);
        vs[1] = mk(24'h800000, 10'd255, 0, 0, 0, 0, 3'b001, 0, 32'h7F7FFFFF, 4'b0101, 2);
        vs[2] = mk(24'hFFFFFF, 10'd254, 1, 1, 0, 0, 3'b010, 0, 32'hFF800000, 4'b0101, 2);
        vs[3] = mk(24'h800000, 10'd255, 1, 0, 0, 0, 3'b011, 0, 32'hFF7FFFFF, 4'b0101, 2);
        vs[4] = mk(24'h000000, 10'd5,   1, 1, 0, 0, 3'b000, 0, 32'h80000000, 4'b0000, 2);
        for (int i = 0; i < 5; i++) begin
            idle();
            send(vs[i], lat);
            checks++;
            if ({bus.float_out, bus.NV, bus.OF, bus.UF, bus.NX, lat} !==
                {vs[i].f, vs[i].fl, vs[i].lat}) begin
                errors++;
                $display("[TB] FAIL ovf_%0d got %h/%b%b%b%b lat %0d exp %h/%b lat %0d", i,
                         bus.float_out, bus.NV, bus.OF, bus.UF, bus.NX, lat, vs[i].f,
                         vs[i].fl, vs[i].lat);
            end
        end
    endtask

    task automatic test_denormal();
        vec_t vs[4];
        int   lat;
        vs[0] = mk(24'h800000, 10'h3FF, 0, 0, 0, 0, 3'b001, 0, 32'h00200000, 4'b0000, 3);
        vs[1] = mk(24'h800000, 10'h3FF, 0, 0, 1, 0, 3'b001, 0, 32'h00200000, 4'b0011, 3);
        vs[2] = mk(24'hFFFFFF, 10'd0,   0, 0, 0, 0, 3'b000, 0, 32'h00800000, 4'b0011, 3);
        vs[3] = mk(24'h800000, 10'h39C, 0, 0, 0, 0, 3'b011, 0, 32'h00000001, 4'b0011, 3);
        for (int i = 0; i < 4; i++) begin
            idle();
            send(vs[i], lat);
            checks++;
            if ({bus.float_out, bus.NV, bus.OF, bus.UF, bus.NX, lat} !==
                {vs[i].f, vs[i].fl, vs[i].lat}) begin
                errors++;
                $display("[TB] FAIL denorm_%0d got %h/%b%b%b%b lat %0d exp %h/%b lat %0d", i,
                         bus.float_out, bus.NV, bus.OF, bus.UF, bus.NX, lat, vs[i].f,
                         vs[i].fl, vs[i].lat);
            end
        end
    endtask

    task automatic test_skip();
        int lat;
        idle();
        send(mk(24'hC00000, 10'd255, 0, 1, 1, 1, 3'b000, 1, 32'h7FC00000, 4'b1000, 1), lat);
        checks++;
        if ({bus.float_out, bus.NV, bus.OF, bus.UF, bus.NX} !== {32'h7FC00000, 4'b1000}) begin
            errors++;
            $display("[TB] FAIL skip got %h/%b%b%b%b exp 7fc00000/1000", bus.float_out,
                     bus.NV, bus.OF, bus.UF, bus.NX);
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL skip_lat got %0d exp 1", lat);
        end
    endtask

    task automatic test_hold();
        int lat;
        idle();
        bus.ready_in = 1'b0;
        send(mk(24'hC00000, 10'd127, 0, 1, 0, 0, 3'b000, 0, 32'h3FC00000, 4'b0001, 2), lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.valid_out, bus.ready_out, bus.float_out, bus.NX} !==
                {1'b1, 1'b0, 32'h3FC00000, 1'b1}) begin
                errors++;
                $display("[TB] FAIL hold_%0d got v=%b rdy=%b f=%h nx=%b exp v=1 rdy=0 f=3fc00000 nx=1",
                         i, bus.valid_out, bus.ready_out, bus.float_out, bus.NX);
            end
        end
        bus.ready_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.valid_out, bus.float_out} !== 33'd0) begin
            errors++;
            $display("[TB] FAIL hold_release got v=%b f=%h exp 0", bus.valid_out, bus.float_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        idle();
        send(mk(24'hC00000, 10'd127, 0, 1, 0, 0, 3'b000, 0, 32'h3FC00000, 4'b0001, 2), lat);
        checks++;
        if (bus.ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready got %b exp 1", bus.ready_out);
        end
        drive(mk(24'h800000, 10'd128, 1, 0, 0, 0, 3'b000, 0, 32'hC0000000, 4'b0000, 2));
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_gap got %b exp 0", bus.valid_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.valid_out, bus.float_out, bus.NX} !== {1'b1, 32'hC0000000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_second got v=%b f=%h nx=%b exp v=1 f=c0000000 nx=0",
                     bus.valid_out, bus.float_out, bus.NX);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        drive(mk(24'hC00000, 10'd127, 0, 1, 0, 0, 3'b000, 0, 32'h3FC00000, 4'b0001, 2));
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.valid_out, bus.float_out, bus.ready_out} !== {1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_reset got v=%b f=%h rdy=%b exp v=0 f=0 rdy=1",
                     bus.valid_out, bus.float_out, bus.ready_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.valid_out, bus.float_out, bus.ready_out} !== {1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_reset_after got v=%b f=%h rdy=%b exp v=0 f=0 rdy=1",
                     bus.valid_out, bus.float_out, bus.ready_out);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.valid_in   = 1'b0;
        bus.ready_in   = 1'b1;
        bus.man_in     = 24'd0;
        bus.exp_in     = 10'd0;
        bus.sgn_in     = 1'b0;
        bus.round_in   = 1'b0;
        bus.sticky_in  = 1'b0;
        bus.IV_in      = 1'b0;
        bus.rm         = 3'd0;
        bus.skip_round = 1'b0;
        test_reset();
        test_rounding();
        test_overflow_zero();
        test_denormal();
        test_skip();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/float_rounder.md
FLOAT_ROUNDER -- requirements
Module: float_rounder

Interface
REQ-001 Module SHALL have no parameters.
REQ-002 clk  in  1  clock; all registers on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 valid_in  in  1  upstream result valid.
REQ-005 ready_out  out  1  block can accept a result.
REQ-006 valid_out  out  1  packed result valid.
REQ-007 ready_in  in  1  downstream accepts result.
REQ-008 man_in  in  24  mantissa, hidden bit at [23].
REQ-009 exp_in  in  10  signed biased exponent.
REQ-010 sgn_in  in  1  sign.
REQ-011 round_in, sticky_in  in  1 each  round and sticky bits below man_in[0].
REQ-012 IV_in  in  1  invalid-operation flag from upstream.
REQ-013 rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes treated as RNE.
REQ-014 skip_round  in  1  pack inputs unchanged.
REQ-015 float_out  out  32  IEEE-754 single result.
REQ-016 NV, OF, UF, NX  out  1 each  exception flags.

Function
REQ-017 ready_out SHALL equal (state==IDLE) && (!valid_out || ready_in).
REQ-018 Accept SHALL occur on valid_in && ready_out; inputs are registered and valid_out is cleared that edge.
REQ-019 FSM states SHALL be IDLE, DENORM, ROUND; accept moves to IDLE if skip_round, DENORM if exp_in<1 and man_in!=0, else ROUND.
REQ-020 skip_round: float_out = {sgn, exp[7:0], man[22:0]}, NV = IV_in, OF=UF=NX=0, valid_out on the 1st edge after accept.
REQ-021 DENORM (one cycle): shift amount s = 1-exp (saturated at 26); man shifted right s, last bit shifted out becomes round, sticky = OR of all other shifted-out bits and old round/sticky, exp := 0, tiny := 1; next state ROUND.
REQ-022 Round increment inc: RNE round&&(sticky||man[0]); RTZ 0; RDN sgn&&(round||sticky); RUP !sgn&&(round||sticky); RMM round.
REQ-023 ROUND (one cycle): 25-bit sum = man + inc; carry at [24] SHALL shift right 1 and increment exp; exp 0 with sum[23]=1 SHALL yield exp 1; then valid_out high, state IDLE.
REQ-024 Latency accept->valid_out SHALL be 2 edges (normal), 3 edges (denormal), 1 edge (skip_round).
REQ-025 Overflow (final exp >= 255): OF=NX=1; result SHALL be infinity {sgn,0xFF,0} except RTZ, RDN with sgn=0, RUP with sgn=1, which give max finite {sgn,0xFE,0x7FFFFF}.
REQ-026 NX SHALL equal round||sticky after DENORM; UF SHALL equal tiny && NX (tininess before rounding); NV SHALL equal IV_in.
REQ-027 man==0 on the non-skip path SHALL produce {sgn,0x00,0} with no flags.
REQ-028 valid_out, float_out and flags SHALL hold stable while valid_out && !ready_in.
REQ-029 valid_out && ready_in with no new accept SHALL clear valid_out and zero float_out and flags.
REQ-030 Accept coincident with downstream handshake SHALL be allowed (back-to-back throughput, one result per 2 cycles normal).

Reset
REQ-031 Reset SHALL force state IDLE, valid_out 0, float_out 0, NV/OF/UF/NX 0, all internal registers 0, at any time including mid-operation; in-flight result is discarded.
REQ-032 ready_out SHALL be 1 during and immediately after reset.

Verification
REQ-033 man=0xC00000, exp=127, sgn=0, round=1, sticky=0, RNE -> 0x3FC00000, NX=1, valid 2 edges after accept.
REQ-034 man=0xFFFFFF, exp=127, round=1, sticky=1, RNE -> carry, 0x40000000, NX=1.
REQ-035 man=0xFFFFFF, exp=254, round=1, RNE -> 0x7F800000, OF=NX=1; man=0x800000, exp=255, RTZ -> 0x7F7FFFFF, OF=NX=1.
REQ-036 man=0x800000, exp=-1, round=sticky=0, RTZ -> 0x00200000, UF=NX=0, 3-edge latency; same with sticky=1 -> UF=NX=1.
REQ-037 skip_round=1, man=0xC00000, exp=255, IV_in=1 -> 0x7FC00000, NV=1, 1-edge latency.
REQ-038 Hold ready_in=0 for 5 cycles after valid_out -> float_out stable, ready_out=0; assert reset during ROUND -> valid_out=0, float_out=0 next cycle.
